// File: rtl/energy_pkg.sv
// Shared constants and state encodings for the energy datapath sequencer.
package energy_pkg;

    localparam int unsigned SQ_LAT     = 1;
    localparam int unsigned ADD_LAT    = 1;
    localparam int unsigned SUM_W      = 39;
    localparam int unsigned SAMPLE_W   = 16;
    localparam int unsigned PIPE_DEPTH = SQ_LAT + ADD_LAT;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_FIN   = 2'd3;

endpackage

// File: rtl/energy_pipe_track.sv
// Valid / first-sample shift register that follows each RAM read through
// the square and adder stages.
module energy_pipe_track
    import energy_pkg::*;
#(
    parameter int unsigned DEPTH = PIPE_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic             first_i,
    output logic [DEPTH-1:0] valid_o,
    output logic             first_o
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] first_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            first_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
            first_q <= '0;
        end else begin
            valid_q <= {valid_q[DEPTH-2:0], valid_i};
            first_q <= {first_q[DEPTH-2:0], first_i & valid_i};
        end
    end

    assign valid_o = valid_q;
    assign first_o = first_q[DEPTH-1];

endmodule

// File: rtl/energy_ctrl.sv
// Energy window sequencer: issues sample reads, tracks them through the
// square/add pipeline and writes the finished sum into the energy register.
module energy_ctrl
    import energy_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              resume,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              square_en,
    output logic              eadder_en,
    output logic              eadder_new,
    output logic              eadder_sel,
    output logic              ereg_we,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W + 1)'(1);

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [ADDR_W:0]   rem_q,      rem_d;
    logic              rd_en_q,    rd_en_d;
    logic              rd_first_q, rd_first_d;
    logic              resume_q,   resume_d;
    logic              we_q,       we_d;
    logic              done_q,     done_d;
    logic              busy_q,     busy_d;

    logic [PIPE_DEPTH-1:0] pipe_valid;
    logic                  pipe_first;
    logic                  last_in_adder;

    energy_pipe_track #(
        .DEPTH (PIPE_DEPTH)
    ) u_track (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (abort),
        .valid_i (rd_en_q),
        .first_i (rd_first_q),
        .valid_o (pipe_valid),
        .first_o (pipe_first)
    );

    // Reads have stopped in DRAIN, so only the adder stage still holding a
    // product means this is the final one.
    assign last_in_adder = pipe_valid[PIPE_DEPTH-1] &&
                           (pipe_valid[PIPE_DEPTH-2:0] == '0);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        rd_en_d    = rd_en_q;
        rd_first_d = 1'b0;
        resume_d   = resume_q;
        we_d       = 1'b0;
        done_d     = 1'b0;
        busy_d     = busy_q;

        if (abort) begin
            state_d = ST_IDLE;
            rd_en_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy_d   = 1'b1;
                        resume_d = resume;
                        if (len == '0) begin
                            state_d = ST_FIN;
                            done_d  = 1'b1;
                        end else begin
                            state_d    = ST_ISSUE;
                            rd_en_d    = 1'b1;
                            rd_first_d = 1'b1;
                            addr_d     = base_addr;
                            rem_d      = len;
                        end
                    end
                end
                ST_ISSUE: begin
                    rem_d = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = ST_DRAIN;
                        rd_en_d = 1'b0;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (last_in_adder) begin
                        state_d = ST_FIN;
                        we_d    = 1'b1;
                        done_d  = 1'b1;
                    end
                end
                ST_FIN: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    rd_en_d = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            rd_en_q    <= 1'b0;
            rd_first_q <= 1'b0;
            resume_q   <= 1'b0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            rd_en_q    <= rd_en_d;
            rd_first_q <= rd_first_d;
            resume_q   <= resume_d;
            we_q       <= we_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign ram_rd_en  = rd_en_q;
    assign ram_addr   = addr_q;
    assign square_en  = pipe_valid[0];
    assign eadder_en  = pipe_valid[PIPE_DEPTH-1];
    assign eadder_new = pipe_first;
    assign eadder_sel = pipe_first & resume_q;
    assign ereg_we    = we_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/energy_ctrl.md
# energy_ctrl

Sequencer for the energy datapath (`square` followed by `eadder`). On a start pulse it reads a window of 16-bit samples from sample RAM, one address per cycle, and drives the square and accumulator enables in lock-step with the datapath pipeline. When the window completes it issues a single write strobe that stores the 39-bit sum into the energy register. It sits between the frame-level control FSM and the `energy` block.

## Interface
Parameters:
- `ADDR_W`, default 8: sample RAM address width. Must be ≤ 8 so that 2^ADDR_W × 31-bit squares fit in 39 bits.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request. Sampled only in IDLE.
- `resume` in 1: sampled with `start`. 1 = add the window onto `ereg_out`; 0 = start a fresh sum.
- `abort` in 1: flushes any operation in progress.
- `base_addr` in ADDR_W: first sample address. Sampled with `start`.
- `len` in ADDR_W+1: window length, 0..2^ADDR_W samples. Sampled with `start`.
- `ram_rd_en` out 1: RAM read strobe. Data is returned on `ram_in` one cycle later.
- `ram_addr` out ADDR_W: read address.
- `square_en` out 1: to `energy.square_en`.
- `eadder_en` out 1: to `energy.eadder_en`.
- `eadder_new` out 1: first product of the window. The adder loads the product instead of accumulating.
- `eadder_sel` out 1: 1 = first product is added to `ereg_out` (resume mode).
- `ereg_we` out 1: energy register write strobe. Captures `eadder_out`.
- `busy` out 1: high from the cycle after an accepted start until the cycle `done` pulses, inclusive.
- `done` out 1: one-cycle completion pulse.

## Operation
- States:
  - IDLE.
  - ISSUE: one RAM read per cycle.
  - DRAIN: wait for the pipeline to empty.
  - FIN: one cycle; `ereg_we` (if len>0) and `done`.
- Transitions:
  - IDLE→ISSUE on `start` with len>0.
  - IDLE→FIN on `start` with len=0. `done` pulses, `ereg_we` stays 0, nothing is read.
  - ISSUE→DRAIN after the read with remaining count 1.
  - DRAIN→FIN when the adder stage has consumed its last product.
  - FIN→IDLE.
- Address generation:
  - Address counter loads `base_addr` and increments modulo 2^ADDR_W each read, so a window wraps past the top of RAM to 0.
  - Remaining-count register loads `len` and decrements per read.
- Pipeline tracking uses a 2-deep valid/first shift register:
  - The read valid becomes `square_en`.
  - The square valid becomes `eadder_en`.
  - A first-sample flag travels alongside the valid and drives `eadder_new`.
  - `eadder_sel` = first flag AND latched `resume`.
  - `eadder_new`/`eadder_sel` are 0 on every non-first product.
- `start` in any state other than IDLE is ignored; no queueing.
- `abort`:
  - Takes effect at the next edge in any state. All valid bits clear and the FSM goes to IDLE.
  - `ereg_we` and `done` are not asserted.
  - The energy register keeps its previous value.
  - `abort` and `start` together in IDLE: abort wins.
- Reset: every output is 0, the FSM is in IDLE, and the counters and valid bits are 0. Reset mid-window discards it.

## Timing
- Start accepted at edge 0:
  - Reads at cycles 1..len.
  - `square_en` at cycles 2..len+1.
  - `eadder_en` at cycles 3..len+2.
  - `ereg_we` and `done` at cycle len+3.
  - `busy` at cycles 1..len+3.
- Start-to-done latency is len+3 cycles; with len=0 it is 1 cycle.
- Throughput is one sample per cycle. A new `start` is accepted at the earliest one cycle after `done` (back-to-back windows cost 1 idle cycle).
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- The shared package (`energy_pkg`) holds:
  - the state enum (IDLE/ISSUE/DRAIN/FIN);
  - constants SQ_LAT=1, ADD_LAT=1, SUM_W=39, SAMPLE_W=16.
- One natural sub-module: `energy_pipe_track`, the valid/first-flag shift register parameterised by SQ_LAT+ADD_LAT.
- The address and count counters stay in the top module.

## Test plan
- base=0x10, len=4, resume=0, RAM[0x10..0x13]=1,2,3,−4 → four reads at 0x10..0x13; `eadder_new` only with the first product; `ereg_we` at cycle 7 capturing 30; `done` at cycle 7.
- base=0xFE, len=4 → read addresses 0xFE, 0xFF, 0x00, 0x01.
- resume=1, ereg=100, len=1, sample=3 → `eadder_new`=`eadder_sel`=1 on the single product; stored value 109; `done` at cycle 4.
- len=0 → `done` at cycle 1; no `ram_rd_en`, `square_en`, `eadder_en`, or `ereg_we`.
- len=8, `abort` at cycle 5 → all strobes 0 from cycle 6; no `ereg_we`/`done`; next `start` accepted normally. Repeat with `rst_n` low at cycle 5 → all outputs 0 immediately.
- len=256, all samples −32768 → sum 256×2^30 = 2^38 stored without overflow; `start` pulses at cycles 10 and 100 are ignored.
